// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Purpose  : Shares one 6-digit 7-segment display and a 10-key keypad among
//            the clock, timer and stopwatch blocks. A timer-done alert
//            preempts all owners and blinks the timer digits.
// Revision : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int BLINK_HALF = 500,
    parameter int ALERT_MAX  = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  dip_sw,
    input  logic [23:0] bcd_clock,
    input  logic [23:0] bcd_timer,
    input  logic [23:0] bcd_stopwatch,
    input  logic        alert_req,
    input  logic [9:0]  keypad,
    output logic [1:0]  grant,
    output logic [2:0]  key_valid,
    output logic [3:0]  key_digit,
    output logic        alert_ack,
    output logic [7:0]  seg_data,
    output logic [7:0]  seg_com
);

    localparam int c_BLINK_W = $clog2(2 * BLINK_HALF);
    localparam int c_ALERT_W = $clog2(ALERT_MAX);

    localparam logic [c_BLINK_W-1:0] c_BLINK_HALF = c_BLINK_W'(BLINK_HALF);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [c_ALERT_W-1:0] c_ALERT_LAST = c_ALERT_W'(ALERT_MAX - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PEND  = 2'd1;
    localparam logic [1:0] c_ST_ALERT = 2'd2;

    localparam logic [1:0] c_OWN_CLOCK = 2'd0;
    localparam logic [1:0] c_OWN_TIMER = 2'd1;
    localparam logic [1:0] c_OWN_SW    = 2'd2;
    localparam logic [1:0] c_OWN_ALERT = 2'd3;

    logic [2:0]           r_scan;
    logic [c_BLINK_W-1:0] r_blink;
    logic [c_ALERT_W-1:0] r_alert_cnt;
    logic [9:0]           r_keypad_prev;
    logic                 r_alert_prev;
    logic [1:0]           r_state;

    logic [1:0]  w_req_owner;
    logic        w_key_onehot;
    logic        w_key_edge;
    logic [3:0]  w_key_index;
    logic        w_alert_rise;
    logic        w_alert_done;
    logic        w_boundary;
    logic [23:0] w_src;
    logic [3:0]  w_nibble;
    logic [7:0]  w_com;
    logic        w_blank;

    // BCD nibble to segment pattern {a,b,c,d,e,f,g,dp}; non-decimal codes go dark
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hFC;
            4'd1:    seg_decode = 8'h60;
            4'd2:    seg_decode = 8'hDA;
            4'd3:    seg_decode = 8'hF2;
            4'd4:    seg_decode = 8'h66;
            4'd5:    seg_decode = 8'hB6;
            4'd6:    seg_decode = 8'hBE;
            4'd7:    seg_decode = 8'hE4;
            4'd8:    seg_decode = 8'hFE;
            4'd9:    seg_decode = 8'hF6;
            default: seg_decode = 8'h00;
        endcase
    endfunction

    // Owner requested by the DIP switches; timer has priority over stopwatch
    always_comb begin
        if (dip_sw[1])      w_req_owner = c_OWN_TIMER;
        else if (dip_sw[2]) w_req_owner = c_OWN_SW;
        else                w_req_owner = c_OWN_CLOCK;
    end

    assign w_key_onehot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign w_key_edge   = w_key_onehot && (r_keypad_prev == 10'd0);
    assign w_alert_rise = alert_req && !r_alert_prev;
    assign w_boundary   = (r_scan == 3'd7);
    assign w_alert_done = (r_state == c_ST_ALERT) && (w_key_edge || (r_alert_cnt == c_ALERT_LAST));
    assign w_blank      = (r_state == c_ST_ALERT) && (r_blink >= c_BLINK_HALF);

    // Binary index of the single pressed key
    always_comb begin
        w_key_index = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) w_key_index = 4'(i);
        end
    end

    // Source digits follow the grant; the alert shows the timer
    always_comb begin
        case (grant)
            c_OWN_TIMER: w_src = bcd_timer;
            c_OWN_SW:    w_src = bcd_stopwatch;
            c_OWN_ALERT: w_src = bcd_timer;
            default:     w_src = bcd_clock;
        endcase
    end

    // Digit nibble and common-line pattern for the current scan position
    always_comb begin
        w_nibble = 4'd0;
        w_com    = 8'hFF;
        case (r_scan)
            3'd0: begin w_nibble = w_src[23:20]; w_com = 8'h7F; end
            3'd1: begin w_nibble = w_src[19:16]; w_com = 8'hBF; end
            3'd2: begin w_nibble = w_src[15:12]; w_com = 8'hDF; end
            3'd3: begin w_nibble = w_src[11:8];  w_com = 8'hEF; end
            3'd4: begin w_nibble = w_src[7:4];   w_com = 8'hF7; end
            3'd5: begin w_nibble = w_src[3:0];   w_com = 8'hFB; end
            default: begin w_nibble = 4'd0;      w_com = 8'hFF; end
        endcase
    end

    // Free-running scan position; 6 and 7 are blank slots that mark the frame end
    always_ff @(posedge clk) begin
        if (rst) r_scan <= 3'd0;
        else     r_scan <= r_scan + 3'd1;
    end

    // Alert FSM plus grant; grant only moves at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            grant       <= c_OWN_CLOCK;
            r_blink     <= '0;
            r_alert_cnt <= '0;
            alert_ack   <= 1'b0;
        end else begin
            alert_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_alert_rise) r_state <= c_ST_PEND;
                end
                c_ST_PEND: begin
                    if (w_boundary) begin
                        r_state     <= c_ST_ALERT;
                        r_blink     <= '0;
                        r_alert_cnt <= '0;
                    end
                end
                c_ST_ALERT: begin
                    if (w_alert_done) begin
                        r_state   <= c_ST_IDLE;
                        alert_ack <= 1'b1;
                    end else begin
                        r_alert_cnt <= r_alert_cnt + 1'b1;
                        r_blink     <= (r_blink == c_BLINK_LAST) ? '0 : r_blink + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
            if (w_boundary) begin
                if ((r_state == c_ST_PEND) || (r_state == c_ST_ALERT)) grant <= c_OWN_ALERT;
                else                                                   grant <= w_req_owner;
            end
        end
    end

    // Edge history and key forwarding; keys are withheld while an alert is pending or shown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keypad_prev <= 10'd0;
            r_alert_prev  <= 1'b0;
            key_valid     <= 3'b000;
            key_digit     <= 4'd0;
        end else begin
            r_keypad_prev <= keypad;
            r_alert_prev  <= alert_req;
            key_valid     <= 3'b000;
            if (w_key_edge && (r_state == c_ST_IDLE) && (grant != c_OWN_ALERT)) begin
                case (grant)
                    c_OWN_TIMER: key_valid <= 3'b010;
                    c_OWN_SW:    key_valid <= 3'b100;
                    default:     key_valid <= 3'b001;
                endcase
                key_digit <= w_key_index;
            end
        end
    end

    // Registered segment drive; blank slots and the dark blink phase turn everything off
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_com  <= 8'hFF;
            seg_data <= 8'h00;
        end else if ((r_scan >= 3'd6) || w_blank) begin
            seg_com  <= 8'hFF;
            seg_data <= 8'h00;
        end else begin
            seg_com  <= w_com;
            seg_data <= seg_decode(w_nibble);
        end
    end

endmodule
`default_nettype wire

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Owns the shared 6-digit 7-segment display and the 10-key keypad for the clock, timer and stopwatch blocks.
- Selects the display owner from the DIP switches and scans that owner's BCD digits onto seg_data/seg_com.
- Forwards keypad presses only to the current owner.
- A timer-done alert preempts every owner and blinks the display until it is dismissed or times out.

Parameters:
- BLINK_HALF, 500, clk cycles per blink half-period during an alert (0.5 s at 1 kHz).
- ALERT_MAX, 10000, clk cycles after which an undismissed alert self-terminates.

Ports:
- clk  in  1  1 kHz system clock.
- rst  in  1  synchronous, active-high reset. One clock; everything is sampled on posedge clk.
- dip_sw  in  3  mode select: [1] timer, [2] stopwatch, [0] clock.
- bcd_clock  in  24  six BCD digits; [23:20] is the leftmost digit (h_ten) and [3:0] the rightmost (s_one).
- bcd_timer  in  24  same format as bcd_clock.
- bcd_stopwatch  in  24  same format as bcd_clock.
- alert_req  in  1  level from the timer, high while the countdown is finished.
- keypad  in  10  one-hot key lines; bit n is digit n.
- grant  out  2  current owner: 0 clock, 1 timer, 2 stopwatch, 3 alert.
- key_valid  out  3  one-cycle pulse to the owner: [0] clock, [1] timer, [2] stopwatch.
- key_digit  out  4  binary value of the forwarded key; valid while key_valid != 0.
- alert_ack  out  1  one-cycle pulse when an alert ends.
- seg_data  out  8  segment pattern.
- seg_com  out  8  digit enables, active-low.

Behaviour:
- Reset values: grant=0, key_valid=0, key_digit=0, alert_ack=0, seg_com=8'hFF, seg_data=8'h00. The scan counter, blink counter, alert counter, keypad_prev and alert_prev are all 0; the FSM is in IDLE.
- Requested owner:
  - dip_sw[1]=1 selects the timer (1).
  - Otherwise dip_sw[2]=1 selects the stopwatch (2).
  - Otherwise, including 000, the clock (0) is selected.
- Scan counter:
  - 3-bit, increments every cycle, wraps 7→0.
  - Positions 0..5 drive seg_com = 7F, BF, DF, EF, F7, FB.
  - Positions 6 and 7 blank the display: seg_com=FF, seg_data=00.
  - Output is registered: seg outputs for position p appear the cycle after the counter equals p.
- Digit source: position p shows nibble bcd_src[23-4p -: 4] of the granted source, decoded with the existing seg_decode. A nibble >9 forces seg_data=00.
- Frame-boundary switching:
  - grant changes only on the cycle the scan counter equals 7, so a frame never mixes sources.
  - Worst-case switch latency is 8 cycles; dip_sw changes between boundaries are simply re-sampled at the next boundary.
- Alert FSM (IDLE, PEND, ALERT):
  - IDLE→PEND on an alert_req rising edge (alert_req=1 and alert_prev=0).
  - PEND→ALERT at the next frame boundary; grant becomes 3 and the blink and alert counters clear.
  - ALERT→IDLE on the first valid key edge or when the alert counter reaches ALERT_MAX-1.
    - alert_ack pulses in that cycle.
    - grant returns to the DIP-selected owner at the next frame boundary.
    - The dismissing key is consumed and not forwarded.
  - alert_req held high does not retrigger; a fresh rising edge is required.
  - A rising edge while in PEND or ALERT is ignored.
- Alert display:
  - Shows bcd_timer digits.
  - Lit while the blink counter < BLINK_HALF, blank (seg_com=FF) for the next BLINK_HALF cycles, then the counter wraps.
- Keypad:
  - A valid edge is keypad one-hot and keypad_prev == 0. Multi-hot or zero presses are ignored, but keypad_prev still updates every cycle.
  - One cycle after a valid edge: key_valid[grant]=1 and key_digit = the key index, using grant as sampled on the edge cycle. key_valid stays 0 if grant=3 or the FSM is in PEND.
  - key_valid is never held for more than 1 cycle, and at most one bit is set.
- rst asserted mid-alert or mid-scan returns everything to the reset values on the next edge, with no alert_ack.

Test Plan:
- Reset release, dip_sw=000, bcd_clock=24'h123456: within cycles 1..6, seg_com steps 7F, BF, DF, EF, F7, FB with seg_data = decode(1..6), then FF/00 twice; grant=0.
- dip_sw 000→010 at scan counter 2: grant stays 0 until the counter reaches 7, then becomes 1. The next frame shows bcd_timer with no mixed digits.
- grant=1, keypad=10'b0000100000 held 5 cycles: exactly one pulse key_valid=3'b010 with key_digit=5. A second press of 10'b0000000110 gives no pulse.
- alert_req rises with grant=2: grant=3 at the next boundary. Blink is lit 500 cycles, blank 500 cycles. Key 7 pressed at cycle 1200 gives alert_ack=1 for 1 cycle, key_valid stays 0, and grant returns to 2 at the next boundary.
- Alert left untouched: alert_ack pulses exactly ALERT_MAX cycles after grant=3. alert_req still high afterwards does not re-enter the alert; a low→high toggle does.
- rst pulsed during ALERT: the next cycle shows grant=0, seg_com=FF, seg_data=00 and alert_ack=0.
